// File: rtl/aes_pkg.sv
// Shared AES constants and the sequencer state encoding.
package aes_pkg;

    localparam int AES_BLK_W     = 128;
    localparam int AES_KEY_W     = 128;
    localparam int AES128_NR     = 10;
    localparam int AES_ROUND_W   = 32;
    localparam int AES_RND_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller. It drives an external combinational
// single-round datapath once per clock and holds the ciphertext until the
// consumer takes it.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLK_W-1:0]   in_data,
    input  logic [AES_KEY_W-1:0]   in_key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLK_W-1:0]   out_data,
    output logic                   busy,
    output logic [AES_ROUND_W-1:0] dp_round,
    output logic [AES_BLK_W-1:0]   dp_data,
    output logic [AES_KEY_W-1:0]   dp_key,
    input  logic [AES_KEY_W-1:0]   dp_key_in,
    input  logic [AES_BLK_W-1:0]   dp_data_in,
    input  logic [AES_BLK_W-1:0]   dp_last_in
);

    localparam logic [AES_RND_CNT_W-1:0] LAST_RND = AES_RND_CNT_W'(NR);

    aes_state_e               st_q;
    logic [AES_BLK_W-1:0]     state_q;
    logic [AES_KEY_W-1:0]     key_q;
    logic [AES_RND_CNT_W-1:0] rnd_q;
    logic [AES_BLK_W-1:0]     out_q;

    // FSM and all datapath registers; reset aborts any block in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            out_q   <= '0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_data ^ in_key;
                        key_q   <= in_key;
                        rnd_q   <= AES_RND_CNT_W'(1);
                        st_q    <= RUN;
                    end
                end
                RUN: begin
                    if (rnd_q == LAST_RND) begin
                        out_q <= dp_last_in;
                        st_q  <= DONE;
                    end else begin
                        state_q <= dp_data_in;
                        key_q   <= dp_key_in;
                        rnd_q   <= rnd_q + AES_RND_CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        st_q <= IDLE;
                    end
                end
                default: begin
                    st_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs decode the state register only
    assign in_ready  = (st_q == IDLE);
    assign busy      = (st_q == RUN);
    assign out_valid = (st_q == DONE);
    assign out_data  = out_q;

    // Datapath feed; the round number is only meaningful while running
    assign dp_round = (st_q == RUN) ? AES_ROUND_W'(rnd_q) : '0;
    assign dp_data  = state_q;
    assign dp_key   = key_q;

endmodule
